// File: rtl/alu_serial_sequencer.sv
// alu_serial_sequencer: bit-serial controller for one external 1-bit ALU slice.
// Each operation runs the slice LSB first for WIDTH clocks, then spends one FINISH cycle
// forming Result, Zero, CarryOut and Overflow. Done pulses in the IDLE cycle that follows.
//
// Handshake: Start is sampled only in IDLE (Busy low); an accepted Start latches the
// operands and ALUControl. Busy is high in RUN and FINISH. Done is a one-cycle pulse, and
// Result and the flags stay valid from that cycle until the next Done. Start raised in the
// Done cycle is accepted, so operations can run back-to-back. Start while Busy is dropped.
//
// Optional feature: define ALU_SEQ_ABORT_EN to add the Abort input. Abort in RUN or FINISH
// returns to IDLE at the next edge, keeps the old Result and flags, and produces no Done.
module alu_serial_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Reset,
`ifdef ALU_SEQ_ABORT_EN
  input  logic             Abort,
`endif
  input  logic             Start,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             CarryOut,
  output logic             Overflow,
  output logic             SliceA,
  output logic             SliceB,
  output logic             SliceLess,
  output logic             SliceCin,
  output logic             SliceAInv,
  output logic             SliceBInv,
  output logic [1:0]       SliceOp,
  input  logic             SliceResult,
  input  logic             SliceCout,
  output logic [1:0]       state_dbg
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [3:0]       ctrl;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             cin_msb;
  logic             cout_msb;
  logic             sum_msb;

  logic             run;
  logic             abort_req;
  logic             is_arith;
  logic             is_slt;
  logic             ovf;
  logic             slt_set;
  logic [WIDTH-1:0] next_result;

`ifdef ALU_SEQ_ABORT_EN
  assign abort_req = Abort;
`else
  assign abort_req = 1'b0;
`endif

  assign run       = (state == S_RUN);
  assign Busy      = (state != S_IDLE);
  assign state_dbg = state;

  // Slice drive: only meaningful in RUN, held at 0 otherwise.
  assign SliceA    = run & a_sh[0];
  assign SliceB    = run & b_sh[0];
  assign SliceCin  = run & carry;
  assign SliceAInv = run & ctrl[3];
  assign SliceBInv = run & ctrl[2];
  assign SliceOp   = run ? ctrl[1:0] : 2'b00;
  assign SliceLess = 1'b0;

  // Result formation: overflow is the carry mismatch across the MSB step; SLT uses the
  // overflow-corrected sign of the subtraction as its single result bit.
  assign is_slt      = (ctrl == 4'b0111);
  assign is_arith    = (ctrl == 4'b0010) || (ctrl == 4'b0110) || is_slt;
  assign ovf         = cin_msb ^ cout_msb;
  assign slt_set     = sum_msb ^ ovf;
  assign next_result = is_slt ? {{(WIDTH-1){1'b0}}, slt_set} : res_sh;

  // Sequencer FSM with shift, carry and registered result/flag outputs.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= S_IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      ctrl     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      cin_msb  <= 1'b0;
      cout_msb <= 1'b0;
      sum_msb  <= 1'b0;
      Result   <= '0;
      Zero     <= 1'b0;
      CarryOut <= 1'b0;
      Overflow <= 1'b0;
      Done     <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Start) begin
            a_sh  <= OperandA;
            b_sh  <= OperandB;
            ctrl  <= ALUControl;
            carry <= ALUControl[2];
            cnt   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (abort_req) begin
            state <= S_IDLE;
          end else begin
            res_sh <= {SliceResult, res_sh[WIDTH-1:1]};
            carry  <= SliceCout;
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            cnt    <= cnt + 1'b1;
            if (cnt == LAST_BIT) begin
              cin_msb  <= carry;
              cout_msb <= SliceCout;
              sum_msb  <= a_sh[0] ^ ctrl[2] ^ b_sh[0] ^ carry;
              state    <= S_FINISH;
            end
          end
        end
        S_FINISH: begin
          if (abort_req) begin
            state <= S_IDLE;
          end else begin
            Result   <= next_result;
            Zero     <= (next_result == '0);
            CarryOut <= cout_msb;
            Overflow <= is_arith & ovf;
            Done     <= 1'b1;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// tb_alu_serial_sequencer: drives alu_serial_sequencer with a behavioural 1-bit slice,
// issues directed and random operations, and checks every Done against a word-level model.
`timescale 1ns/1ps
module tb_alu_serial_sequencer;

  localparam int W = 16;
  localparam int PERIOD = 10;

  logic         Clock;
  logic         Reset;
`ifdef ALU_SEQ_ABORT_EN
  logic         Abort;
`endif
  logic         Start;
  logic [3:0]   ALUControl;
  logic [W-1:0] OperandA;
  logic [W-1:0] OperandB;
  logic         Busy;
  logic         Done;
  logic [W-1:0] Result;
  logic         Zero;
  logic         CarryOut;
  logic         Overflow;
  logic         SliceA;
  logic         SliceB;
  logic         SliceLess;
  logic         SliceCin;
  logic         SliceAInv;
  logic         SliceBInv;
  logic [1:0]   SliceOp;
  logic         SliceResult;
  logic         SliceCout;
  logic [1:0]   state_dbg;

  int n_checks = 0;
  int n_fail = 0;

  // Expected {result, zero, carry, overflow} and the accept time of each issued operation.
  logic [W+2:0] exp_q[$];
  time          t_q[$];
  logic [W-1:0] last_result = '0;

  alu_serial_sequencer #(.WIDTH(W)) dut (
    .Clock(Clock),
    .Reset(Reset),
`ifdef ALU_SEQ_ABORT_EN
    .Abort(Abort),
`endif
    .Start(Start),
    .ALUControl(ALUControl),
    .OperandA(OperandA),
    .OperandB(OperandB),
    .Busy(Busy),
    .Done(Done),
    .Result(Result),
    .Zero(Zero),
    .CarryOut(CarryOut),
    .Overflow(Overflow),
    .SliceA(SliceA),
    .SliceB(SliceB),
    .SliceLess(SliceLess),
    .SliceCin(SliceCin),
    .SliceAInv(SliceAInv),
    .SliceBInv(SliceBInv),
    .SliceOp(SliceOp),
    .SliceResult(SliceResult),
    .SliceCout(SliceCout),
    .state_dbg(state_dbg)
  );

  // Clock and watchdog.
  initial Clock = 1'b0;
  always #(PERIOD/2) Clock = ~Clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $fatal(1, "watchdog");
  end

  // Behavioural 1-bit ALU slice (inverters, AND/OR/adder/less mux, full-adder carry).
  logic sa, sb;
  always_comb begin
    sa = SliceA ^ SliceAInv;
    sb = SliceB ^ SliceBInv;
    SliceCout = (sa & sb) | (sa & SliceCin) | (sb & SliceCin);
    case (SliceOp)
      2'b00:   SliceResult = sa & sb;
      2'b01:   SliceResult = sa | sb;
      2'b10:   SliceResult = sa ^ sb ^ SliceCin;
      default: SliceResult = SliceLess;
    endcase
  end

  // Word-level reference: {result, zero, carry, overflow}.
  function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [3:0] c);
    logic [W-1:0] x, y, r, d;
    logic [W:0]   full;
    logic         ov;
    x = c[3] ? ~a : a;
    y = c[2] ? ~b : b;
    full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c[2]};
    d = a - b;
    case (c[1:0])
      2'b00:   r = x & y;
      2'b01:   r = x | y;
      2'b10:   r = full[W-1:0];
      default: r = '0;
    endcase
    ov = 1'b0;
    if (c == 4'b0010) ov = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    else if (c == 4'b0110 || c == 4'b0111) ov = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
    if (c == 4'b0111) r = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
    return {r, (r == '0), full[W], ov};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per Done and checks value, flags and latency.
  always @(negedge Clock) begin
    logic [W+2:0] e;
    time          t_acc;
    if (!Reset && Done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        t_acc = t_q.pop_front();
        check("result", Result, e[W+2:3]);
        check("zero", W'(Zero), W'(e[2]));
        check("carry_out", W'(CarryOut), W'(e[1]));
        check("overflow", W'(Overflow), W'(e[0]));
        check("latency", W'(($time - t_acc) / PERIOD), W'(W + 1));
        last_result = e[W+2:3];
      end
    end
  end

  // Driver: wait (bounded) until the sequencer can accept a Start, at a falling edge.
  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      if (!Busy) return;
      @(negedge Clock);
    end
    check("idle_timeout", 1'b1, 1'b0);
  endtask

  // Driver: present one operation for one clock, recording its expectation.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] c);
    OperandA = a;
    OperandB = b;
    ALUControl = c;
    Start = 1'b1;
    exp_q.push_back(model(a, b, c));
    @(posedge Clock);
    t_q.push_back($time);
    @(negedge Clock);
    Start = 1'b0;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] c);
    wait_idle();
    issue(a, b, c);
  endtask

  logic [3:0] codes [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};

  // Stimulus sequence.
  initial begin
    Reset = 1'b1;
    Start = 1'b0;
    ALUControl = '0;
    OperandA = '0;
    OperandB = '0;
`ifdef ALU_SEQ_ABORT_EN
    Abort = 1'b0;
`endif
    repeat (3) @(negedge Clock);
    check("rst_busy", W'(Busy), '0);
    check("rst_done", W'(Done), '0);
    check("rst_result", Result, '0);
    check("rst_flags", W'({Zero, CarryOut, Overflow}), '0);
    check("rst_slice", W'({SliceA, SliceB, SliceLess, SliceCin, SliceAInv, SliceBInv, SliceOp}), '0);
    check("rst_state", W'(state_dbg), '0);
    Reset = 1'b0;
    @(negedge Clock);

    // Directed cases.
    run_op(16'h7FFF, 16'h0001, 4'b0010);
    run_op(16'h1234, 16'h1234, 4'b0110);
    run_op(16'h8000, 16'h0001, 4'b0111);
    run_op(16'h0005, 16'hFFFF, 4'b0111);
    run_op(16'hF0F0, 16'hFF00, 4'b0000);
    run_op(16'hF0F0, 16'hFF00, 4'b0001);
    run_op(16'hF0F0, 16'hFF00, 4'b1100);
    run_op(16'hFFFF, 16'h0001, 4'b0010);
    run_op(16'h8000, 16'h0001, 4'b0110);

    // Start pulses mid-operation are dropped; the next Start lands in the Done cycle.
    run_op(16'h1111, 16'h2222, 4'b0010);
    repeat (2) @(negedge Clock);
    Start = 1'b1;
    OperandA = 16'(($urandom));
    ALUControl = 4'b0001;
    @(negedge Clock);
    Start = 1'b0;
    check("busy_ignore3", W'(Busy), W'(1));
    repeat (6) @(negedge Clock);
    Start = 1'b1;
    OperandB = 16'(($urandom));
    @(negedge Clock);
    Start = 1'b0;
    check("busy_ignore10", W'(Busy), W'(1));
    run_op(16'hABCD, 16'h1234, 4'b0110);

    // Randomized operations, mostly listed codes, some raw slice controls.
    for (int i = 0; i < 40; i++) begin
      logic [3:0] c;
      c = ($urandom_range(0, 4) == 0) ? 4'($urandom) : codes[$urandom_range(0, 5)];
      run_op(16'($urandom), 16'($urandom), c);
    end

    // Reset eight cycles into RUN: outputs clear, no Done follows.
    run_op(16'h00F0, 16'h0F00, 4'b0001);
    wait_idle();
    issue(16'h4444, 16'h3333, 4'b0010);
    repeat (7) @(negedge Clock);
    Reset = 1'b1;
    exp_q.delete();
    t_q.delete();
    #1;
    check("midrst_busy", W'(Busy), '0);
    check("midrst_result", Result, '0);
    check("midrst_flags", W'({Done, Zero, CarryOut, Overflow}), '0);
    @(negedge Clock);
    Reset = 1'b0;
    repeat (25) @(negedge Clock);

`ifdef ALU_SEQ_ABORT_EN
    // Abort eight cycles into RUN: previous result held, no Done.
    run_op(16'h0F0F, 16'h00FF, 4'b0001);
    wait_idle();
    @(negedge Clock);
    issue(16'h5555, 16'h2222, 4'b0010);
    repeat (7) @(negedge Clock);
    Abort = 1'b1;
    exp_q.delete();
    t_q.delete();
    @(negedge Clock);
    Abort = 1'b0;
    check("abort_busy", W'(Busy), '0);
    check("abort_result", Result, last_result);
    repeat (25) @(negedge Clock);
    run_op(16'h0003, 16'h0004, 4'b0010);
`endif

    run_op(16'h0001, 16'h0001, 4'b0110);
    wait_idle();
    repeat (25) @(negedge Clock);
    check("queue_drained", W'(exp_q.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
